// File: rtl/ifetch_unit_if.sv
// Instruction memory request/response bus for the fetch stage.
// Single outstanding request; response arrives one or more cycles later.
interface ifetch_unit_if #(
    parameter int DW = 32
);
    logic          req;
    logic [DW-1:0] addr;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC generation, single-outstanding imem requests,
// one-entry skid buffer for decode stalls and flush on EX redirects.
module ifetch_unit #(
    parameter int            DW       = 32,
    parameter logic [DW-1:0] RESET_PC = '0,
    parameter logic [DW-1:0] NOP      = DW'(32'h0000_0013)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 jump_en_i,
    input  logic [DW-1:0]        jump_addr_i,
    input  logic                 hold_i,
    ifetch_unit_if.master        imem,
    output logic [DW-1:0]        inst_o,
    output logic [DW-1:0]        inst_addr_o,
    output logic                 inst_valid_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP,
        S_FULL
    } state_t;

    state_t        state_q, state_d;

    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] req_addr_q, req_addr_d;
    logic [DW-1:0] buf_inst_q, buf_inst_d;
    logic [DW-1:0] buf_addr_q, buf_addr_d;
    logic [DW-1:0] inst_q, inst_d;
    logic [DW-1:0] inst_addr_q, inst_addr_d;
    logic          inst_valid_q, inst_valid_d;

    logic          rsp;
    logic          req;
    logic          out_mem;
    logic          out_buf;
    logic          out_bub;
    logic          buf_load;

    assign rsp = imem.rvalid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect overrides everything else
    always_comb begin
        state_d = state_q;
        if (jump_en_i) begin
            if ((state_q == S_WAIT || state_q == S_DROP) && !rsp) begin
                state_d = S_DROP;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp && hold_i) begin
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (!hold_i) begin
                        state_d = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (rsp) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output/control decode; request is held low while in reset
    always_comb begin
        req      = 1'b0;
        out_mem  = 1'b0;
        out_buf  = 1'b0;
        buf_load = 1'b0;
        if (rst_n && !jump_en_i) begin
            unique case (state_q)
                S_IDLE: begin
                    req = !hold_i;
                end
                S_WAIT: begin
                    req      = rsp && !hold_i;
                    out_mem  = rsp && !hold_i;
                    buf_load = rsp && hold_i;
                end
                S_FULL: begin
                    out_buf = !hold_i;
                end
                S_DROP: begin
                    req = 1'b0;
                end
                default: req = 1'b0;
            endcase
        end
        out_bub = !jump_en_i && !hold_i && !out_mem && !out_buf;
    end

    assign imem.req  = req;
    assign imem.addr = pc_q;

    // Program counter and tag of the outstanding request
    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if (jump_en_i) begin
            pc_d = {jump_addr_i[DW-1:2], 2'b00};
        end else if (req) begin
            pc_d       = pc_q + DW'(4);
            req_addr_d = pc_q;
        end
    end

    // Skid buffer catches a response that lands while decode is stalled
    always_comb begin
        buf_inst_d = buf_inst_q;
        buf_addr_d = buf_addr_q;
        if (buf_load) begin
            buf_inst_d = imem.rdata;
            buf_addr_d = req_addr_q;
        end
    end

    // Output register select: flush, fresh response, buffer, or bubble
    always_comb begin
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        inst_valid_d = inst_valid_q;
        unique case (1'b1)
            jump_en_i: begin
                inst_d       = NOP;
                inst_addr_d  = '0;
                inst_valid_d = 1'b0;
            end
            out_mem: begin
                inst_d       = imem.rdata;
                inst_addr_d  = req_addr_q;
                inst_valid_d = 1'b1;
            end
            out_buf: begin
                inst_d       = buf_inst_q;
                inst_addr_d  = buf_addr_q;
                inst_valid_d = 1'b1;
            end
            out_bub: begin
                inst_valid_d = 1'b0;
            end
            default: begin
                inst_valid_d = inst_valid_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            buf_inst_q   <= NOP;
            buf_addr_q   <= '0;
            inst_q       <= NOP;
            inst_addr_q  <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            buf_inst_q   <= buf_inst_d;
            buf_addr_q   <= buf_addr_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign inst_valid_o = inst_valid_q;

endmodule
